// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bus bundle between N Wishbone masters, the round-robin arbiter and the
// single shared slave.
//   m_cyc/m_stb/m_we/m_adr/m_dat_w/m_sel : per-master requests, packed, master i at slice i
//   m_ack/m_err                          : per-master responses
//   m_dat_r                              : read data broadcast to every master
//   s_cyc/s_stb/s_we/s_adr/s_dat_w/s_sel : request forwarded to the slave
//   s_ack/s_err/s_dat_r                  : slave response
//   grant                                : one-hot current owner, zero when idle
// Modports:
//   master : arbiter view (it masters the slave-side bus)
//   slave  : environment view (masters and slave around the arbiter)
// ---------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
    parameter int unsigned N_MASTERS     = 2,
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32
);
    localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;

    // master side
    logic [N_MASTERS-1:0]               m_cyc;
    logic [N_MASTERS-1:0]               m_stb;
    logic [N_MASTERS-1:0]               m_we;
    logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_adr;
    logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_dat_w;
    logic [N_MASTERS*SEL_W-1:0]         m_sel;
    logic [N_MASTERS-1:0]               m_ack;
    logic [N_MASTERS-1:0]               m_err;
    logic [WB_DATA_WIDTH-1:0]           m_dat_r;

    // slave side
    logic                               s_cyc;
    logic                               s_stb;
    logic                               s_we;
    logic [WB_ADDR_WIDTH-1:0]           s_adr;
    logic [WB_DATA_WIDTH-1:0]           s_dat_w;
    logic [SEL_W-1:0]                   s_sel;
    logic                               s_ack;
    logic                               s_err;
    logic [WB_DATA_WIDTH-1:0]           s_dat_r;

    logic [N_MASTERS-1:0]               grant;

    modport master (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        output m_ack, m_err, m_dat_r,
        output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        input  s_ack, s_err, s_dat_r,
        output grant
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  m_ack, m_err, m_dat_r,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        output s_ack, s_err, s_dat_r,
        input  grant
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter letting N Wishbone masters share one slave. Ownership
// is locked for as long as the owner holds CYC; every release passes through
// IDLE, so consecutive grants are separated by at least one idle cycle.
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset
//   bus  : wb_rr_arbiter_if.master (master requests/responses, slave bus, grant)
// Optional feature:
//   WB_RR_ARBITER_TIMEOUT_EN : when defined, a stalled beat (STB high, no
//   ACK/ERR) lasting TIMEOUT_CYCLES cycles returns a one-cycle ERR to the
//   owner and suppresses the slave STB for that cycle; the grant is kept.
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int unsigned N_MASTERS      = 2,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic            clk,
    input logic            rstn,
    wb_rr_arbiter_if.master bus
);

    localparam int unsigned SEL_W = WB_DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    // Elaboration-time parameter sanity checks
    if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_n_masters
        $error("wb_rr_arbiter: N_MASTERS must be in 2..8");
    end
    if ((WB_DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("wb_rr_arbiter: WB_DATA_WIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]     last_idx_q, last_idx_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;

    logic [IDX_W-1:0]     rr_win_c;
    logic [31:0]          rr_cand_c;
    logic                 rr_found_c;
    logic                 timeout_c;

    // Round-robin search: first requester upward from last_idx+1, wrapping
    always_comb begin
        rr_found_c = 1'b0;
        rr_win_c   = last_idx_q;
        rr_cand_c  = '0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            rr_cand_c = 32'(last_idx_q) + k;
            if (rr_cand_c >= N_MASTERS) begin
                rr_cand_c = rr_cand_c - N_MASTERS;
            end
            if (!rr_found_c && bus.m_cyc[rr_cand_c[IDX_W-1:0]]) begin
                rr_found_c = 1'b1;
                rr_win_c   = rr_cand_c[IDX_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(N_MASTERS - 1);
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            grant_q    <= grant_d;
        end
    end

    // Next-state and bus outputs
    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        last_idx_d  = last_idx_q;
        grant_d     = grant_q;

        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = bus.m_adr[gnt_idx_q*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        bus.s_dat_w = bus.m_dat_w[gnt_idx_q*WB_DATA_WIDTH +: WB_DATA_WIDTH];
        bus.s_sel   = bus.m_sel[gnt_idx_q*SEL_W +: SEL_W];
        bus.m_ack   = '0;
        bus.m_err   = '0;

        case (state_q)
            IDLE: begin
                if (rr_found_c) begin
                    state_d   = BUSY;
                    gnt_idx_d = rr_win_c;
                    grant_d   = N_MASTERS'(1) << rr_win_c;
                end
            end
            BUSY: begin
                bus.s_cyc = bus.m_cyc[gnt_idx_q];
                bus.s_stb = bus.m_stb[gnt_idx_q] & ~timeout_c;
                bus.s_we  = bus.m_we[gnt_idx_q];
                // Responses are masked while reset is asserted so an aborted
                // beat never completes towards the master.
                if (rstn) begin
                    bus.m_ack[gnt_idx_q] = bus.s_ack;
                    bus.m_err[gnt_idx_q] = bus.s_err | timeout_c;
                end
                if (!bus.m_cyc[gnt_idx_q]) begin
                    state_d    = IDLE;
                    last_idx_d = gnt_idx_q;
                    grant_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            stall_c;

    assign stall_c   = (state_q == BUSY) && bus.m_cyc[gnt_idx_q] && bus.m_stb[gnt_idx_q]
                       && !bus.s_ack && !bus.s_err;
    assign timeout_c = (state_q == BUSY) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Stall counter; IDLE clears it, which covers every change of owner
    always_ff @(posedge clk) begin
        if (!rstn || state_q != BUSY || bus.s_ack || bus.s_err || timeout_c) begin
            to_cnt_q <= '0;
        end else if (stall_c) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign timeout_c = 1'b0;
`endif

    assign bus.grant   = grant_q;
    assign bus.m_dat_r = bus.s_dat_r;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Directed bench for wb_rr_arbiter with two masters; expected values are
// hand-derived cycle by cycle. Timeout checks follow WB_RR_ARBITER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    localparam logic [31:0] ADR0 = 32'h1000_0000;
    localparam logic [31:0] ADR1 = 32'h2000_0004;
    localparam logic [31:0] DAT0 = 32'hA5A5_0001;
    localparam logic [31:0] DAT1 = 32'h5A5A_0002;
    localparam logic [3:0]  SEL0 = 4'hF;
    localparam logic [3:0]  SEL1 = 4'h3;
    localparam logic [31:0] RDAT = 32'hCAFE_F00D;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_if #(.N_MASTERS(N), .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW)) bus ();

    wb_rr_arbiter #(
        .N_MASTERS     (N),
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn          = 1'b0;
        bus.m_cyc     = 2'b11;
        bus.m_stb     = 2'b11;
        bus.m_we      = 2'b00;
        bus.m_adr     = {ADR1, ADR0};
        bus.m_dat_w   = {DAT1, DAT0};
        bus.m_sel     = {SEL1, SEL0};
        bus.s_ack     = 1'b0;
        bus.s_err     = 1'b0;
        bus.s_dat_r   = RDAT;

        // reset state
        tick(); tick(); settle();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_s_cyc", 32'(bus.s_cyc), 32'h0);
        chk("rst_m_ack", 32'(bus.m_ack), 32'h0);

        // reset release with both requesting: master 0 first
        rstn = 1'b1;
        tick(); settle();
        chk("rel_grant", 32'(bus.grant), 32'h1);
        chk("rel_s_adr", bus.s_adr, ADR0);
        chk("rel_s_cyc", 32'(bus.s_cyc), 32'h1);
        chk("rel_dat_r", bus.m_dat_r, RDAT);

        // rotation: 01,00,10,00,01
        bus.s_ack = 1'b1; settle();
        chk("rot_ack0", 32'(bus.m_ack), 32'h1);
        tick(); bus.m_cyc = 2'b10; bus.s_ack = 1'b0; settle();
        chk("rot_rel0_grant", 32'(bus.grant), 32'h1);
        chk("rot_rel0_s_cyc", 32'(bus.s_cyc), 32'h0);
        tick(); bus.m_cyc = 2'b11; settle();
        chk("rot_idle0_grant", 32'(bus.grant), 32'h0);
        chk("rot_idle0_s_cyc", 32'(bus.s_cyc), 32'h0);
        tick(); settle();
        chk("rot_g1_grant", 32'(bus.grant), 32'h2);
        chk("rot_g1_s_adr", bus.s_adr, ADR1);
        bus.s_ack = 1'b1; settle();
        chk("rot_ack1", 32'(bus.m_ack), 32'h2);
        tick(); bus.m_cyc = 2'b01; bus.s_ack = 1'b0; settle();
        chk("rot_rel1_grant", 32'(bus.grant), 32'h2);
        tick(); bus.m_cyc = 2'b11; settle();
        chk("rot_idle1_grant", 32'(bus.grant), 32'h0);
        tick(); settle();
        chk("rot_g0_grant", 32'(bus.grant), 32'h1);

        // master 1 locked over 4 beats while master 0 keeps requesting
        bus.m_cyc = 2'b10; settle();
        tick(); bus.m_cyc = 2'b11; settle();
        chk("lock_idle_grant", 32'(bus.grant), 32'h0);
        tick();
        for (int b = 0; b < 4; b++) begin
            bus.s_ack = 1'b1; settle();
            chk("lock_grant", 32'(bus.grant), 32'h2);
            chk("lock_m_ack", 32'(bus.m_ack), 32'h2);
            tick();
        end
        bus.m_cyc = 2'b01; bus.s_ack = 1'b0; settle();
        chk("lock_drop_grant", 32'(bus.grant), 32'h2);
        chk("lock_drop_m_ack", 32'(bus.m_ack), 32'h0);
        tick(); settle();
        chk("lock_gap_grant", 32'(bus.grant), 32'h0);
        tick(); settle();
        chk("lock_m0_grant", 32'(bus.grant), 32'h1);

        // slave error on a master 0 write
        bus.m_we = 2'b01; bus.s_err = 1'b1; settle();
        chk("err_m_err", 32'(bus.m_err), 32'h1);
        chk("err_m_ack", 32'(bus.m_ack), 32'h0);
        chk("err_s_we", 32'(bus.s_we), 32'h1);
        chk("err_s_dat_w", bus.s_dat_w, DAT0);
        chk("err_s_sel", 32'(bus.s_sel), 32'(SEL0));

        // hand over to master 1, then reset mid-beat
        tick(); bus.s_err = 1'b0; bus.m_we = 2'b00; bus.m_cyc = 2'b10; settle();
        tick(); bus.m_cyc = 2'b11; settle();
        tick(); settle();
        chk("pre_rst_grant", 32'(bus.grant), 32'h2);
        chk("pre_rst_s_cyc", 32'(bus.s_cyc), 32'h1);
        rstn = 1'b0; bus.s_ack = 1'b1; settle();
        chk("rst_mid_m_ack", 32'(bus.m_ack), 32'h0);
        tick(); settle();
        chk("rst_after_s_cyc", 32'(bus.s_cyc), 32'h0);
        chk("rst_after_grant", 32'(bus.grant), 32'h0);
        chk("rst_after_m_ack", 32'(bus.m_ack), 32'h0);
        chk("rst_after_m_err", 32'(bus.m_err), 32'h0);
        tick(); bus.s_ack = 1'b0; rstn = 1'b1; settle();
        tick(); settle();
        chk("rst2_grant", 32'(bus.grant), 32'h1);

        // hung slave: master 0 owns the bus, STB high, never acked
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        for (int i = 0; i < int'(TO); i++) begin
            chk("to_stall_m_err", 32'(bus.m_err), 32'h0);
            tick();
        end
        chk("to_pulse_m_err", 32'(bus.m_err), 32'h1);
        chk("to_pulse_s_stb", 32'(bus.s_stb), 32'h0);
        chk("to_pulse_grant", 32'(bus.grant), 32'h1);
        tick();
        chk("to_after_m_err", 32'(bus.m_err), 32'h0);
        chk("to_after_s_stb", 32'(bus.s_stb), 32'h1);
        chk("to_after_grant", 32'(bus.grant), 32'h1);
`else
        for (int i = 0; i < 40; i++) begin
            chk("hang_m_err", 32'(bus.m_err), 32'h0);
            chk("hang_grant", 32'(bus.grant), 32'h1);
            tick();
        end
        chk("hang_s_stb", 32'(bus.s_stb), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
